// File: rtl/dm_stage_pkg.sv
// Shared MIPS memory-stage definitions: access-size encodings and default RAM depth.
package dm_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int DM_DEPTH_LOG2 = 12;

endpackage

// File: rtl/dm_stage_load_ext.sv
// Load lane select and sign/zero extension for byte, halfword and word loads.
module dm_load_ext
    import dm_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        ext      = 32'h0;
        case (size)
            SIZE_BYTE: ext = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
            SIZE_HALF: ext = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
            SIZE_WORD: ext = word;
            default:   ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Memory-stage data memory: async-read RAM, lane-merged stores, misalign/range detect.
// Optional store trace printed when DM_TRACE_EN is defined.
module dm_stage
    import dm_stage_pkg::*;
#(
    parameter int DEPTH_LOG2 = DM_DEPTH_LOG2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           ram [WORDS];
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           cur_word;
    logic [31:0]           merged;
    logic [31:0]           ext;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  store_ok;
    logic                  load_ok;

    assign idx      = addr[DEPTH_LOG2+1:2];
    assign lane     = addr[1:0];
    assign cur_word = ram[idx];

    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = lane[0];
            SIZE_WORD: misaligned = (lane != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    assign out_of_range = (addr[31:DEPTH_LOG2+2] != '0);
    assign addr_err     = mem_en & (misaligned | out_of_range);
    assign store_ok     = mem_en & mem_we & ~addr_err;
    assign load_ok      = mem_en & ~mem_we & ~addr_err;

    // Bytes outside the addressed lane keep their current value.
    always_comb begin
        merged = cur_word;
        case (mem_size)
            SIZE_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (lane[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            SIZE_WORD: merged = wdata;
            default:   merged = cur_word;
        endcase
    end

    // Reset wins over a store issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++)
                ram[i] <= 32'h0;
        end else if (store_ok) begin
            ram[idx] <= merged;
        end
    end

    dm_load_ext u_load_ext (
        .word          (cur_word),
        .lane          (lane),
        .size          (mem_size),
        .load_unsigned (load_unsigned),
        .ext           (ext)
    );

    assign rdata = load_ok ? ext : 32'h0;

`ifdef DM_TRACE_EN
    always @(posedge clk) begin
        if (!reset && store_ok)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: byte-array reference model, directed plan then random traffic.
module tb_dm_stage;
    import dm_stage_pkg::*;

    localparam int MEM_BYTES = 4 << DM_DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] rdata;
    logic        addr_err;

    typedef struct {
        string       name;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  bmem [MEM_BYTES];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dm_stage dut (
        .clk           (clk),
        .reset         (reset),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .pc            (pc),
        .rdata         (rdata),
        .addr_err      (addr_err)
    );

    // Reference: memory is a flat little-endian byte array; values are built arithmetically.
    task automatic issue(input string name, input logic rst, input logic en, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          nbytes;
        longint      val;
        logic        err;
        @(posedge clk);
        #1;
        reset = rst; mem_en = en; mem_we = we; mem_size = size;
        load_unsigned = uns; addr = a; wdata = wd; pc = pc + 4;
        nbytes = 1 << size;
        err = en && (size == 2'b11 || (a % nbytes) != 0 || a >= MEM_BYTES);
        val = 0;
        if (en && !we && !err) begin
            for (int i = 0; i < nbytes; i++)
                val = val + (longint'(bmem[a + i]) << (8 * i));
            if (!uns && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
                val = val - (longint'(1) << (8 * nbytes));
        end
        e.name = name;
        e.exp_rdata = val[31:0];
        e.exp_err = err;
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++)
                bmem[i] = 8'h0;
        end else if (en && we && !err) begin
            for (int i = 0; i < nbytes; i++)
                bmem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        reset = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rdata !== e.exp_rdata || addr_err !== e.exp_err) begin
                errors++;
                $display("FAIL %s: got rdata=%h addr_err=%b, want rdata=%h addr_err=%b",
                         e.name, rdata, addr_err, e.exp_rdata, e.exp_err);
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++)
            bmem[i] = 8'h0;

        issue("reset0", 1, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0);
        issue("reset1", 1, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0);
        issue("lw_0_after_reset", 0, 1, 0, SIZE_WORD, 0, 32'h0, 32'h0);
        issue("lw_3ffc_after_reset", 0, 1, 0, SIZE_WORD, 0, 32'h3FFC, 32'h0);

        issue("sw_10", 0, 1, 1, SIZE_WORD, 0, 32'h10, 32'h12345678);
        issue("sb_11", 0, 1, 1, SIZE_BYTE, 0, 32'h11, 32'hFFFFFFAB);
        issue("lw_10_merged", 0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        issue("lbu_11", 0, 1, 0, SIZE_BYTE, 1, 32'h11, 32'h0);
        issue("lb_11", 0, 1, 0, SIZE_BYTE, 0, 32'h11, 32'h0);

        issue("sh_22", 0, 1, 1, SIZE_HALF, 0, 32'h22, 32'h55558001);
        issue("lh_22", 0, 1, 0, SIZE_HALF, 0, 32'h22, 32'h0);
        issue("lhu_22", 0, 1, 0, SIZE_HALF, 1, 32'h22, 32'h0);
        issue("lw_20", 0, 1, 0, SIZE_WORD, 0, 32'h20, 32'h0);

        issue("sw_12_misaligned", 0, 1, 1, SIZE_WORD, 0, 32'h12, 32'hCAFEF00D);
        issue("lw_10_unchanged", 0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        issue("lh_13_misaligned", 0, 1, 0, SIZE_HALF, 0, 32'h13, 32'h0);
        issue("sw_4000_range", 0, 1, 1, SIZE_WORD, 0, 32'h4000, 32'h11111111);
        issue("lw_0_no_wrap", 0, 1, 0, SIZE_WORD, 0, 32'h0, 32'h0);
        issue("reserved_size", 0, 1, 0, 2'b11, 0, 32'h10, 32'h0);
        issue("disabled_rdata0", 0, 0, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        issue("store_rdata0", 0, 1, 1, SIZE_WORD, 0, 32'h3FFC, 32'h0BADF00D);
        issue("lw_3ffc_top", 0, 1, 0, SIZE_WORD, 0, 32'h3FFC, 32'h0);

        issue("sw_3ffc_with_reset", 1, 1, 1, SIZE_WORD, 0, 32'h3FFC, 32'hDEADBEEF);
        issue("lw_3ffc_dropped", 0, 1, 0, SIZE_WORD, 0, 32'h3FFC, 32'h0);
        issue("lw_10_cleared", 0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0);
        issue("sw_3ffc_commit", 0, 1, 1, SIZE_WORD, 0, 32'h3FFC, 32'hA5A5_5A5A);
        issue("lb_3fff", 0, 1, 0, SIZE_BYTE, 0, 32'h3FFF, 32'h0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            int          pick;
            pick = $urandom_range(0, 9);
            if (pick < 6)
                a = $urandom_range(0, 63);
            else if (pick < 9)
                a = 32'h3FF0 + $urandom_range(0, 23);
            else
                a = $urandom;
            issue("random", ($urandom_range(0, 79) == 0), ($urandom_range(0, 5) != 0),
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, a, $urandom);
        end

        idle();
        idle();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory-stage data memory for the five-stage MIPS pipeline. It sits between the E/M and M/W pipeline registers. It takes the ALU result as a byte address and the forwarded rt value as store data, and performs word, halfword and byte loads and stores against an on-chip RAM. Load data is returned combinationally, sign- or zero-extended, so it can be captured as RDM by the M/W register in the same cycle. Misaligned or out-of-range accesses are suppressed and flagged.

## Interface
- DEPTH_LOG2, 12: RAM holds 2^DEPTH_LOG2 32-bit words (default 16 KiB).
- clk  in  1  clock; all RAM writes on posedge.
- reset  in  1  synchronous, active-high; clears every RAM word.
- mem_en  in  1  valid memory access this cycle.
- mem_we  in  1  1 = store, 0 = load (meaningful only when mem_en=1).
- mem_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- load_unsigned  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend (lb/lh); ignored for word and for stores.
- addr  in  32  byte address (ALUoutM).
- wdata  in  32  store data; byte uses [7:0], half uses [15:0].
- pc  in  32  PC of the instruction in M, used only by the trace.
- rdata  out  32  extended load data (to RDM).
- addr_err  out  1  access is misaligned, out of range or reserved size.

## Operation
- word index = addr[DEPTH_LOG2+1:2]; lane = addr[1:0].
- addr_err = mem_en & (size==11 | (size==10 & lane!=0) | (size==01 & lane[0]) | addr[31:DEPTH_LOG2+2]!=0). It is purely combinational.
- Store (mem_en & mem_we & !addr_err): read-modify-write of the indexed word.
  - byte: replace lane addr[1:0] (lane 0 = bits [7:0]) with wdata[7:0].
  - half: replace bits [15:0] if addr[1]=0, else bits [31:16], with wdata[15:0].
  - word: replace the whole word.
  - Bytes outside the selected lane are preserved.
- Load (mem_en & !mem_we & !addr_err): select the byte or half by lane and extend it to 32 bits.
  - Sign-extend when load_unsigned=0.
  - Zero-extend when load_unsigned=1.
  - Word loads pass through unchanged.
- rdata = 0 whenever there is no valid load: mem_en=0, store, or addr_err=1.
- An access with addr_err=1 never modifies the RAM.

## Timing
- Read path is asynchronous (address to rdata with 0 cycles of latency). The RAM is read as it stands before the current edge.
- Store commits at the posedge that ends its M cycle. A load of the same address in the next cycle returns the new value.
- There is no handshake and no stall. One access per cycle, with no internal state besides the RAM.
- Reset:
  - All words become 0 at the posedge where reset=1.
  - reset takes priority over a store in the same cycle, so that store is dropped.
  - Outputs after reset: rdata=0, and addr_err follows its inputs.
- Reset asserted mid-program discards all prior stores. There is no partial-clear state.
- Highest valid word (index 2^DEPTH_LOG2-1) is accessible. The address one past it sets addr_err; the index does not wrap.

## Configuration
- DM_TRACE_EN defined: on every committed store, print `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)` at the posedge. merged_word is the full 32-bit word after lane merge. Nothing is printed for suppressed stores or during reset.
- DM_TRACE_EN undefined: no simulation output. Functional behaviour is identical.

## Structure
- The shared MIPS definitions package holds:
  - mem_size encodings SIZE_BYTE / SIZE_HALF / SIZE_WORD.
  - The DEPTH_LOG2 default.
- Sub-module dm_load_ext: combinational lane select plus sign or zero extension (inputs word, lane, size, load_unsigned). It is reused by any future cache/bridge.
- Top level holds the RAM array, the store merge and the addr_err logic.

## Test plan
- reset, then lw 0x0 and lw 0x3FFC: rdata=0x00000000 for both.
- sw 0x12345678 @0x10; sb 0xAB @0x11; lw @0x10 → 0x1234AB78. lbu @0x11 → 0x000000AB. lb @0x11 → 0xFFFFFFAB.
- sh 0x8001 @0x22; lh @0x22 → 0xFFFF8001; lhu @0x22 → 0x00008001; lw @0x20 → 0x80010000.
- sw @0x12 → addr_err=1, RAM unchanged (lw @0x10 still 0x1234AB78). lh @0x13 → addr_err=1, rdata=0. sw @0x4000 with DEPTH_LOG2=12 → addr_err=1, no write.
- sw 0xDEADBEEF @0x3FFC with reset=1 in the same cycle → next lw @0x3FFC = 0. With DM_TRACE_EN there is no print. A later committed sw prints exactly one line with pc, address and merged word.
